// File: rtl/fpu_ss_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_ss_core_arbiter
// Description : Round-robin arbiter that shares one FPU subsystem issue port
//               among NB_CORES cores, with grant locking while the FPU stalls,
//               per-core outstanding-instruction limits and result routing.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_ss_core_arbiter #(
    parameter int NB_CORES        = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CW              = (NB_CORES > 1) ? $clog2(NB_CORES) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NB_CORES-1:0]    core_issue_valid_i,
    output logic [NB_CORES-1:0]    core_issue_ready_o,
    input  logic [NB_CORES*32-1:0] core_issue_instr_i,
    input  logic [NB_CORES*4-1:0]  core_issue_id_i,
    output logic                   fpu_issue_valid_o,
    input  logic                   fpu_issue_ready_i,
    output logic [31:0]            fpu_issue_instr_o,
    output logic [3:0]             fpu_issue_id_o,
    output logic [CW-1:0]          fpu_issue_core_o,
    input  logic                   fpu_result_valid_i,
    output logic                   fpu_result_ready_o,
    input  logic [CW-1:0]          fpu_result_core_i,
    output logic [NB_CORES-1:0]    core_result_valid_o,
    input  logic [NB_CORES-1:0]    core_result_ready_i,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [0:0]    c_idle    = 1'b0;
    localparam logic [0:0]    c_locked  = 1'b1;
    localparam logic [OW-1:0] c_max_out = OW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] c_last    = CW'(NB_CORES - 1);

    logic [0:0]          r_state;
    logic [CW-1:0]       r_ptr;
    logic [CW-1:0]       r_win;
    logic                r_err;
    logic [OW-1:0]       r_outst [NB_CORES];

    logic [NB_CORES-1:0] w_elig;
    logic [NB_CORES-1:0] w_nz;
    logic [NB_CORES-1:0] w_inc;
    logic [NB_CORES-1:0] w_res_hs;
    logic                w_rr_found;
    logic [CW-1:0]       w_rr_win;
    logic                w_gnt_valid;
    logic [CW-1:0]       w_gnt_core;
    logic                w_issue_hs;
    logic                w_lock_drop;
    logic                w_res_hit;
    logic                w_res_drop;
    logic                w_underflow;

    // Per-core eligibility, counter status and counter update strobes
    generate
        for (genvar k = 0; k < NB_CORES; k++) begin : g_core
            assign w_elig[k]   = core_issue_valid_i[k] && (r_outst[k] < c_max_out);
            assign w_nz[k]     = (r_outst[k] != '0);
            assign w_inc[k]    = w_issue_hs && (w_gnt_core == CW'(k));
            assign w_res_hs[k] = core_result_valid_o[k] & core_result_ready_i[k];

            // Outstanding counter: +1 on issue, -1 on result, hold when both
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_outst[k] <= '0;
                end else if (w_inc[k] && !w_res_hs[k]) begin
                    r_outst[k] <= r_outst[k] + OW'(1);
                end else if (!w_inc[k] && w_res_hs[k] && w_nz[k]) begin
                    r_outst[k] <= r_outst[k] - OW'(1);
                end
            end
        end
    endgenerate

    // Round-robin scan: first eligible core starting at r_ptr, wrapping
    always_comb begin
        int idx;
        idx        = 0;
        w_rr_found = 1'b0;
        w_rr_win   = '0;
        // Scan downwards so the lowest offset from r_ptr is assigned last
        for (int i = NB_CORES - 1; i >= 0; i--) begin
            idx = (int'(r_ptr) + i) % NB_CORES;
            if (w_elig[idx]) begin
                w_rr_found = 1'b1;
                w_rr_win   = CW'(idx);
            end
        end
    end

    // Grant selection: locked core while LOCKED, arbitration winner otherwise
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_core  = '0;
        if (r_state == c_locked) begin
            w_gnt_core = r_win;
            for (int k = 0; k < NB_CORES; k++) begin
                if (r_win == CW'(k)) begin
                    w_gnt_valid = core_issue_valid_i[k];
                end
            end
        end else begin
            w_gnt_valid = w_rr_found;
            w_gnt_core  = w_rr_win;
        end
    end

    assign w_issue_hs  = w_gnt_valid & fpu_issue_ready_i;
    assign w_lock_drop = (r_state == c_locked) && !w_gnt_valid;

    // Issue datapath mux; all fields forced to zero when nothing is granted
    always_comb begin
        fpu_issue_valid_o  = w_gnt_valid;
        fpu_issue_instr_o  = '0;
        fpu_issue_id_o     = '0;
        fpu_issue_core_o   = '0;
        core_issue_ready_o = '0;
        if (w_gnt_valid) begin
            fpu_issue_core_o = w_gnt_core;
            for (int k = 0; k < NB_CORES; k++) begin
                if (w_gnt_core == CW'(k)) begin
                    fpu_issue_instr_o     = core_issue_instr_i[32*k +: 32];
                    fpu_issue_id_o        = core_issue_id_i[4*k +: 4];
                    core_issue_ready_o[k] = fpu_issue_ready_i;
                end
            end
        end
    end

    // Result routing; an index with no matching core is accepted and dropped
    always_comb begin
        core_result_valid_o = '0;
        fpu_result_ready_o  = 1'b1;
        w_res_hit           = 1'b0;
        for (int k = 0; k < NB_CORES; k++) begin
            if (fpu_result_core_i == CW'(k)) begin
                w_res_hit              = 1'b1;
                core_result_valid_o[k] = fpu_result_valid_i;
                fpu_result_ready_o     = core_result_ready_i[k];
            end
        end
    end

    assign w_res_drop  = fpu_result_valid_i && !w_res_hit;
    assign w_underflow = |(w_res_hs & ~w_inc & ~w_nz);

    // Arbitration state, round-robin pointer and sticky error flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_idle;
            r_ptr   <= '0;
            r_win   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_rr_found && !w_issue_hs) begin
                        r_state <= c_locked;
                        r_win   <= w_rr_win;
                    end
                end
                c_locked: begin
                    if (w_issue_hs || w_lock_drop) begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
            if (w_issue_hs) begin
                r_ptr <= (w_gnt_core == c_last) ? '0 : w_gnt_core + CW'(1);
            end
            r_err <= r_err | w_lock_drop | w_res_drop | w_underflow;
        end
    end

    assign busy_o = (r_state == c_locked) || (|w_nz);
    assign err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fpu_ss_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_ss_core_arbiter
// Description : Self-checking bench for fpu_ss_core_arbiter: vector table,
//               directed corner sequences, randomized run against a
//               behavioural model, plus a 6-core instance for index range.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_ss_core_arbiter;

    localparam int N  = 8;
    localparam int N6 = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-core instance
    logic [N-1:0]    civ, cir, crv, crr;
    logic [N*32-1:0] cinstr;
    logic [N*4-1:0]  cid;
    logic            fiv, fir, frv, frr, busy, err;
    logic [31:0]     finstr;
    logic [3:0]      fid;
    logic [2:0]      fcore, frc;

    // 6-core instance
    logic [N6-1:0]    civ6, cir6, crv6, crr6;
    logic [N6*32-1:0] cinstr6;
    logic [N6*4-1:0]  cid6;
    logic             fiv6, fir6, frv6, frr6, busy6, err6;
    logic [31:0]      finstr6;
    logic [3:0]       fid6;
    logic [2:0]       fcore6, frc6;

    fpu_ss_core_arbiter #(.NB_CORES(N), .MAX_OUTSTANDING(4)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .core_issue_valid_i(civ), .core_issue_ready_o(cir),
        .core_issue_instr_i(cinstr), .core_issue_id_i(cid),
        .fpu_issue_valid_o(fiv), .fpu_issue_ready_i(fir),
        .fpu_issue_instr_o(finstr), .fpu_issue_id_o(fid), .fpu_issue_core_o(fcore),
        .fpu_result_valid_i(frv), .fpu_result_ready_o(frr), .fpu_result_core_i(frc),
        .core_result_valid_o(crv), .core_result_ready_i(crr),
        .busy_o(busy), .err_o(err)
    );

    fpu_ss_core_arbiter #(.NB_CORES(N6), .MAX_OUTSTANDING(4)) u_dut6 (
        .clk_i(clk), .rst_i(rst),
        .core_issue_valid_i(civ6), .core_issue_ready_o(cir6),
        .core_issue_instr_i(cinstr6), .core_issue_id_i(cid6),
        .fpu_issue_valid_o(fiv6), .fpu_issue_ready_i(fir6),
        .fpu_issue_instr_o(finstr6), .fpu_issue_id_o(fid6), .fpu_issue_core_o(fcore6),
        .fpu_result_valid_i(frv6), .fpu_result_ready_o(frr6), .fpu_result_core_i(frc6),
        .core_result_valid_o(crv6), .core_result_ready_i(crr6),
        .busy_o(busy6), .err_o(err6)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] v;    logic rdy; logic rv; logic [2:0] rc; logic [7:0] crr;
        logic       ev;   logic [2:0] core; logic [7:0] crdy;
        logic       rr;   logic [7:0] cv;   logic busy;
    } vec_t;
    vec_t tbl[8];

    // Behavioural model state: counts per core, rotating start, held grant
    int m_out[N];
    int m_ptr;
    int m_lock;
    bit m_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        civ = '0; fir = 1'b0; frv = 1'b0; frc = '0; crr = '0;
        civ6 = '0; fir6 = 1'b0; frv6 = 1'b0; frc6 = '0; crr6 = '0;
    endtask

    task automatic fill_instr();
        for (int k = 0; k < N; k++) begin
            cinstr[32*k +: 32] = 32'hC0DE_0000 + 32'(k);
            cid[4*k +: 4]      = 4'(k);
        end
        for (int k = 0; k < N6; k++) begin
            cinstr6[32*k +: 32] = 32'hBEEF_0000 + 32'(k);
            cid6[4*k +: 4]      = 4'(k + 8);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic issue_chk(input string nm, input logic e_ev, input int e_core);
        chk({nm, "_valid"}, fiv, e_ev);
        chk({nm, "_core"},  fcore, e_ev ? e_core : 0);
        chk({nm, "_ready"}, cir, (e_ev && fir) ? (64'd1 << e_core) : 64'd0);
        chk({nm, "_instr"}, finstr, e_ev ? 32'hC0DE_0000 + e_core : 0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_out[k] = 0;
        m_ptr  = 0;
        m_lock = -1;
        m_err  = 0;
    endtask

    // Which core the model expects on the FPU port this cycle
    task automatic model_predict(output bit ev, output int g);
        ev = 0;
        g  = 0;
        if (m_lock >= 0) begin
            if (civ[m_lock]) begin ev = 1; g = m_lock; end
        end else begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (!ev && civ[k] && m_out[k] < 4) begin ev = 1; g = k; end
            end
        end
    endtask

    task automatic model_step(input bit ev, input int g);
        bit hs;
        hs = ev && fir;
        for (int k = 0; k < N; k++) begin
            bit inc, dec;
            inc = hs && (g == k);
            dec = frv && (int'(frc) == k) && crr[k];
            if (inc && !dec) m_out[k]++;
            else if (dec && !inc) begin
                if (m_out[k] == 0) m_err = 1;
                else m_out[k]--;
            end
        end
        if (hs) begin
            m_ptr  = (g + 1) % N;
            m_lock = -1;
        end else if (m_lock >= 0 && !ev) begin
            m_err  = 1;
            m_lock = -1;
        end else if (m_lock < 0 && ev) begin
            m_lock = g;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        bit e_ev;
        int e_g;
        bit m_busy;
        int cand[$];

        rst = 1'b1;
        idle_inputs();
        fill_instr();
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // ---------------- vector table from reset ----------------
        //               v    rdy  rv   rc    crr    ev   core  crdy   rr   cv     busy
        tbl[0] = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{8'h04, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h04, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{8'h05, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[3] = '{8'h80, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h00, 1'b0, 8'h00, 1'b1};
        tbl[4] = '{8'h81, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[5] = '{8'h00, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0, 3'd0, 8'h00, 1'b1, 8'h04, 1'b1};
        tbl[6] = '{8'h00, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 8'h01, 1'b1};
        tbl[7] = '{8'h00, 1'b0, 1'b0, 3'd3, 8'h08, 1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 1'b1};
        for (int i = 0; i < 8; i++) begin
            civ = tbl[i].v; fir = tbl[i].rdy; frv = tbl[i].rv; frc = tbl[i].rc; crr = tbl[i].crr;
            #4;
            chk($sformatf("tbl%0d_valid", i), fiv, tbl[i].ev);
            chk($sformatf("tbl%0d_core", i), fcore, tbl[i].core);
            chk($sformatf("tbl%0d_cready", i), cir, tbl[i].crdy);
            chk($sformatf("tbl%0d_instr", i), finstr, tbl[i].ev ? 32'hC0DE_0000 + tbl[i].core : 0);
            chk($sformatf("tbl%0d_id", i), fid, tbl[i].ev ? tbl[i].core : 0);
            chk($sformatf("tbl%0d_rready", i), frr, tbl[i].rr);
            chk($sformatf("tbl%0d_rvalid", i), crv, tbl[i].cv);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_err", i), err, 1'b0);
            next_cycle();
        end

        // ---------------- all cores valid, ready held high ----------------
        do_reset();
        civ = 8'hFF; fir = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #4;
            issue_chk($sformatf("rr%0d", i), 1'b1, i % 8);
            next_cycle();
        end

        // ---------------- lock on stalled core 3, then wrap to core 1 ------------
        do_reset();
        civ = 8'h08; fir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #4; issue_chk($sformatf("lock_wait%0d", i), 1'b1, 3); next_cycle();
        end
        civ = 8'h0A;
        #4; issue_chk("lock_hold", 1'b1, 3); next_cycle();
        fir = 1'b1;
        #4; issue_chk("lock_grant3", 1'b1, 3); next_cycle();
        #4; issue_chk("lock_next1", 1'b1, 1); next_cycle();

        // ---------------- outstanding limit on core 2 ----------------
        do_reset();
        civ = 8'h04; fir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #4; issue_chk($sformatf("lim%0d", i), 1'b1, 2); next_cycle();
        end
        #4; issue_chk("lim_full", 1'b0, 0); chk("lim_busy", busy, 1'b1); next_cycle();
        frv = 1'b1; frc = 3'd2; crr = 8'h04;
        #4; issue_chk("lim_res", 1'b0, 0); chk("lim_rready", frr, 1'b1); chk("lim_rvalid", crv, 8'h04);
        next_cycle();
        frv = 1'b0;
        #4; issue_chk("lim_again", 1'b1, 2); next_cycle();

        // ---------------- same-cycle issue and result for core 5 ----------------
        do_reset();
        civ = 8'h20; fir = 1'b1;
        #4; issue_chk("same0", 1'b1, 5); next_cycle();
        frv = 1'b1; frc = 3'd5; crr = 8'h20;
        #4; issue_chk("same_both", 1'b1, 5); chk("same_rvalid", crv, 8'h20); next_cycle();
        frv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #4; issue_chk($sformatf("same_fill%0d", i), 1'b1, 5); next_cycle();
        end
        #4; issue_chk("same_full", 1'b0, 0); chk("same_err", err, 1'b0); next_cycle();

        // ---------------- locked request withdrawn ----------------
        do_reset();
        civ = 8'h10; fir = 1'b0;
        #4; issue_chk("drop_lock", 1'b1, 4); next_cycle();
        civ = 8'h00;
        #4; issue_chk("drop_gone", 1'b0, 0); chk("drop_err_pre", err, 1'b0); next_cycle();
        #4; chk("drop_err", err, 1'b1); chk("drop_busy", busy, 1'b0); next_cycle();
        civ = 8'hFF; fir = 1'b1;
        #4; issue_chk("drop_ptr", 1'b1, 0); next_cycle();

        // ---------------- reset while LOCKED with counters nonzero ----------------
        do_reset();
        civ = 8'h10; fir = 1'b0; next_cycle();
        civ = 8'h00; next_cycle();
        civ = 8'h01; fir = 1'b1; next_cycle(); next_cycle();
        civ = 8'h02; fir = 1'b0;
        #4; issue_chk("rst_pre", 1'b1, 1); chk("rst_pre_busy", busy, 1'b1); chk("rst_pre_err", err, 1'b1);
        next_cycle();
        rst = 1'b1; next_cycle(); rst = 1'b0;
        civ = 8'h00;
        #4; issue_chk("rst_post", 1'b0, 0); chk("rst_busy", busy, 1'b0); chk("rst_err", err, 1'b0);
        next_cycle();
        civ = 8'hFF; fir = 1'b1;
        #4; issue_chk("rst_ptr", 1'b1, 0); next_cycle();

        // ---------------- randomized run against the model ----------------
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            civ = 8'($urandom);
            fir = 1'($urandom_range(0, 1));
            for (int k = 0; k < N; k++) cinstr[32*k +: 32] = $urandom;
            cid = 32'($urandom);
            crr = 8'($urandom);
            cand.delete();
            for (int k = 0; k < N; k++) if (m_out[k] > 0) cand.push_back(k);
            frv = 1'b0;
            frc = 3'($urandom);
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                frv = 1'b1;
                frc = 3'(cand[$urandom_range(0, cand.size() - 1)]);
            end
            #4;
            model_predict(e_ev, e_g);
            m_busy = (m_lock >= 0);
            for (int k = 0; k < N; k++) if (m_out[k] > 0) m_busy = 1;
            chk($sformatf("rnd%0d_valid", c), fiv, e_ev);
            chk($sformatf("rnd%0d_core", c), fcore, e_ev ? e_g : 0);
            chk($sformatf("rnd%0d_instr", c), finstr, e_ev ? cinstr[32*e_g +: 32] : 32'd0);
            chk($sformatf("rnd%0d_id", c), fid, e_ev ? cid[4*e_g +: 4] : 4'd0);
            chk($sformatf("rnd%0d_cready", c), cir, (e_ev && fir) ? (64'd1 << e_g) : 64'd0);
            chk($sformatf("rnd%0d_rready", c), frr, crr[frc]);
            chk($sformatf("rnd%0d_rvalid", c), crv, frv ? (64'd1 << frc) : 64'd0);
            chk($sformatf("rnd%0d_busy", c), busy, m_busy);
            chk($sformatf("rnd%0d_err", c), err, m_err);
            model_step(e_ev, e_g);
            next_cycle();
        end

        // ---------------- 6-core instance: wrap and out-of-range results -------
        fill_instr();
        do_reset();
        civ6 = 6'h3F; fir6 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #4;
            chk($sformatf("w6_%0d_valid", i), fiv6, 1'b1);
            chk($sformatf("w6_%0d_core", i), fcore6, i % 6);
            chk($sformatf("w6_%0d_instr", i), finstr6, 32'hBEEF_0000 + (i % 6));
            chk($sformatf("w6_%0d_id", i), fid6, (i % 6) + 8);
            chk($sformatf("w6_%0d_cready", i), cir6, 64'd1 << (i % 6));
            next_cycle();
        end
        civ6 = '0; fir6 = 1'b0;
        frv6 = 1'b1; frc6 = 3'd6; crr6 = 6'h3F;
        #4; chk("oor6_rready", frr6, 1'b1); chk("oor6_rvalid", crv6, 6'h00); chk("oor6_err_pre", err6, 1'b0);
        next_cycle();
        frv6 = 1'b0; frc6 = 3'd7; crr6 = 6'h00;
        #4; chk("oor6_err", err6, 1'b1); chk("oor7_rready", frr6, 1'b1); next_cycle();
        frv6 = 1'b1; frc6 = 3'd5; crr6 = 6'h20;
        #4; chk("in6_rvalid", crv6, 6'h20); chk("in6_rready", frr6, 1'b1); chk("in6_busy", busy6, 1'b1);
        next_cycle();
        frv6 = 1'b0;
        #4; chk("in6_err_sticky", err6, 1'b1); next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
